// File: rtl/multi_button_debouncer_pkg.sv
// Shared timing defaults and counter-width helpers for the button debouncer.
package multi_button_debouncer_pkg;

    // Defaults for the 100 MHz board clock: 1 ms sample tick.
    localparam int unsigned DEF_N_BTN        = 5;
    localparam int unsigned DEF_TICK_DIV     = 100000;
    localparam int unsigned DEF_STABLE_TICKS = 10;
    localparam int unsigned DEF_HOLD_TICKS   = 500;
    localparam int unsigned DEF_SYNC_STAGES  = 2;

    // Prescaler counts 0..tick_div-1.
    function automatic int unsigned tick_w(input int unsigned tick_div);
        return $clog2(tick_div);
    endfunction

    // Stability counter must be able to hold stable_ticks.
    function automatic int unsigned stab_w(input int unsigned stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    // Hold counter saturates at hold_ticks.
    function automatic int unsigned hold_w(input int unsigned hold_ticks);
        return $clog2(hold_ticks + 1);
    endfunction

endpackage

// File: rtl/multi_button_debouncer_debounce_channel.sv
// One button channel: synchroniser, stability counter, level/edge registers
// and long-press hold counter. Advances only on the shared sample tick.
module multi_button_debouncer_debounce_channel
    import multi_button_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int unsigned STAB_W = stab_w(STABLE_TICKS);
    localparam int unsigned HOLD_W = hold_w(HOLD_TICKS);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   samp;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    assign samp = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Next-state for stability counter, level, edge pulses and hold counter.
    always_comb begin
        stab_d    = stab_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            if (samp == level_q) begin
                // Any matching sample restarts qualification.
                stab_d = '0;
            end else if (stab_q == STAB_MAX) begin
                stab_d    = '0;
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
            if (level_q && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + 1'b1;
            end
        end
        // Hold state ends on the same edge the release pulse is raised.
        if (release_d) begin
            hold_d = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stab_q    <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = (hold_q == HOLD_MAX);

endmodule

// File: rtl/multi_button_debouncer.sv
// Multi-button debouncer: one shared sample-tick prescaler driving N_BTN
// independent debounce channels.
module multi_button_debouncer
    import multi_button_debouncer_pkg::*;
#(
    parameter int unsigned N_BTN        = DEF_N_BTN,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic             sample_tick
);

    localparam int unsigned TICK_W = tick_w(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    if ((STABLE_TICKS < 1) || (HOLD_TICKS < 1) || (TICK_DIV < 2) || (SYNC_STAGES < 2))
    begin : g_bad_params
        $fatal(1, "multi_button_debouncer: illegal parameter combination");
    end

    logic [TICK_W-1:0] tick_cnt_q;

    // Free-running prescaler, wrapping after TICK_DIV cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick_cnt_q == TICK_MAX) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign sample_tick = (tick_cnt_q == TICK_MAX);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        multi_button_debouncer_debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .tick        (sample_tick),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_hold    (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus random button
// activity, every cycle compared against a window-based reference model.
module tb_multi_button_debouncer;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int S  = 3;
    localparam int H  = 5;
    localparam int SY = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_hold;
    logic         sample_tick;

    always #5 clock = ~clock;

    multi_button_debouncer #(
        .N_BTN        (N),
        .TICK_DIV     (D),
        .STABLE_TICKS (S),
        .HOLD_TICKS   (H),
        .SYNC_STAGES  (SY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .sample_tick (sample_tick)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state as seen right after the most recent clock edge.
    logic [N-1:0] m_level, m_press, m_release;
    int           m_held [N];     // ticks spent debounced-high, capped at H
    int           m_cyc;          // edges since reset was last sampled high
    logic [N-1:0] m_sync [$];     // raw values still in flight to the sample point
    logic [S-1:0] m_win  [N];     // most recent S tick samples, newest in bit 0
    int           m_fill [N];

    task automatic model_reset();
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_cyc     = 0;
        m_sync    = {};
        for (int k = 0; k < SY; k++) m_sync.push_back('0);
        for (int i = 0; i < N; i++) begin
            m_held[i] = 0;
            m_win[i]  = '0;
            m_fill[i] = 0;
        end
    endtask

    // Level flips once the last S tick samples all disagree with it.
    task automatic model_edge(input logic rst, input logic [N-1:0] raw);
        logic         tick;
        logic [N-1:0] samp;
        if (rst) begin
            model_reset();
            return;
        end
        tick      = ((m_cyc % D) == D - 1);
        samp      = m_sync[0];
        m_press   = '0;
        m_release = '0;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                m_win[i] = (m_win[i] << 1) | S'(samp[i]);
                if (m_fill[i] < S) m_fill[i]++;
                if (m_level[i] && m_held[i] < H) m_held[i]++;
                if (m_fill[i] == S && m_win[i] == {S{~m_level[i]}}) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                    end else begin
                        m_release[i] = 1'b1;
                        m_held[i]    = 0;
                    end
                end
            end
        end
        void'(m_sync.pop_front());
        m_sync.push_back(raw);
        m_cyc++;
    endtask

    logic both_seen = 1'b0;
    logic hold_seen = 1'b0;

    task automatic compare_outputs();
        logic [N-1:0] exp_hold;
        for (int i = 0; i < N; i++) exp_hold[i] = (m_held[i] >= H);
        check_eq("sample_tick", 32'(sample_tick), 32'((m_cyc % D) == D - 1));
        check_eq("btn_level", 32'(btn_level), 32'(m_level));
        check_eq("btn_press", 32'(btn_press), 32'(m_press));
        check_eq("btn_release", 32'(btn_release), 32'(m_release));
        check_eq("btn_hold", 32'(btn_hold), 32'(exp_hold));
    endtask

    // One cycle: check current outputs, then drive inputs for the next edge.
    task automatic step(input logic rst, input logic [N-1:0] raw);
        @(negedge clock);
        compare_outputs();
        if (btn_press == 2'b11) both_seen = 1'b1;
        if (btn_hold[0]) hold_seen = 1'b1;
        reset   = rst;
        btn_raw = raw;
        model_edge(rst, raw);
    endtask

    initial begin
        logic [N-1:0] raw;
        reset   = 1'b1;
        btn_raw = '0;
        model_reset();
        repeat (2) @(negedge clock);

        // Idle after reset release: only the prescaler moves.
        for (int c = 0; c < 40; c++) step(1'b0, 2'b00);

        // Long press on channel 0 through debounce and hold.
        for (int c = 0; c < 50; c++) step(1'b0, 2'b01);

        // Short glitches on channel 1 while channel 0 stays held.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 6; c++) step(1'b0, 2'b11);
            for (int c = 0; c < 2; c++) step(1'b0, 2'b01);
        end
        for (int c = 0; c < 20; c++) step(1'b0, 2'b01);

        // Release channel 0 after hold.
        for (int c = 0; c < 30; c++) step(1'b0, 2'b00);

        // Both buttons pressed together, then released together.
        for (int c = 0; c < 30; c++) step(1'b0, 2'b11);
        for (int c = 0; c < 30; c++) step(1'b0, 2'b00);

        // Reset while channel 0 is debounced high and still held.
        for (int c = 0; c < 20; c++) step(1'b0, 2'b01);
        step(1'b1, 2'b01);
        for (int c = 0; c < 30; c++) step(1'b0, 2'b01);
        for (int c = 0; c < 30; c++) step(1'b0, 2'b00);

        // Random bouncing with occasional resets.
        raw = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) raw[i] = ~raw[i];
            end
            step($urandom_range(0, 499) == 0, raw);
        end
        step(1'b0, raw);

        check_eq("both_press_same_cycle", 32'(both_seen), 32'd1);
        check_eq("hold_reached_ch0", 32'(hold_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- Parametrised successor to the single-flop 1 ms button sampler.
- Debounces N_BTN raw pushbutton inputs against one shared sample-tick prescaler.
- Per channel outputs: a clean level, one-cycle press and release pulses, and a long-press hold flag.
- Sits between board buttons and all game/UI control logic; replaces per-button divider + flop instances.

Parameters:
- N_BTN, 5, number of independent button channels.
- TICK_DIV, 100000, clock cycles per sample tick (100 MHz -> 1 ms).
- STABLE_TICKS, 10, consecutive ticks a new value must persist before the level changes.
- HOLD_TICKS, 500, ticks of continuous debounced-high level before btn_hold asserts.
- SYNC_STAGES, 2, synchroniser depth on each raw input; minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button inputs, active-high.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse on each debounced rising edge.
- btn_release  out  N_BTN  one-cycle pulse on each debounced falling edge.
- btn_hold  out  N_BTN  high while the button has been held for at least HOLD_TICKS.
- sample_tick  out  1  prescaler tick, one cycle wide, exported for reuse.

Behaviour:
- Reset behaviour:
  - One clock; reset is synchronous and active-high, sampled on rising clock.
  - While reset is high, all outputs are 0 and all counters and synchroniser flops are 0.
- Synchroniser:
  - Each btn_raw bit passes through SYNC_STAGES flops. The last stage is "samp".
- Prescaler:
  - Counter 0..TICK_DIV-1; sample_tick=1 when count==TICK_DIV-1, then count wraps to 0.
  - First tick occurs TICK_DIV cycles after reset deasserts.
  - Counter width is $clog2(TICK_DIV).
- Per-channel stability counter:
  - Only updated on cycles where sample_tick=1.
  - If samp==btn_level: counter cleared to 0.
  - If samp!=btn_level and counter<STABLE_TICKS-1: counter increments.
  - If samp!=btn_level and counter==STABLE_TICKS-1: btn_level toggles at that edge and the counter clears.
  - A glitch shorter than STABLE_TICKS ticks never changes btn_level; any intermediate matching sample restarts the count.
- Edge pulses:
  - btn_press / btn_release are registered and assert in the same cycle btn_level first shows the new value, for exactly one clock.
  - They never assert together on one channel.
- Hold flag:
  - A hold counter increments on ticks while btn_level=1 and saturates at HOLD_TICKS.
  - btn_hold=1 once the counter reaches HOLD_TICKS.
  - When btn_level falls, the hold counter and btn_hold clear in the same cycle btn_release asserts.
- Channel independence: channels are fully independent. Simultaneous transitions on several channels all produce pulses in the same cycle.
- Latency: worst-case raw-to-level latency is SYNC_STAGES + STABLE_TICKS*TICK_DIV cycles. Best case is one tick shorter.
- Reset mid-operation: reset mid-press drops btn_level to 0 with no release pulse. A button still held afterwards re-qualifies and produces a fresh btn_press.
- Legal parameter range: STABLE_TICKS>=1, HOLD_TICKS>=1, TICK_DIV>=2. Other values are illegal; an elaboration check stops the build.

Decomposition:
- Shared package/header holds width helpers:
  - TICK_W=$clog2(TICK_DIV)
  - STAB_W=$clog2(STABLE_TICKS+1)
  - HOLD_W=$clog2(HOLD_TICKS+1)
  - The default timing constants for the 100 MHz board clock.
- Sub-module debounce_channel contains the synchroniser, stability counter, level/pulse regs and hold counter for one button.
- The top level contains the prescaler and a generate loop of N_BTN debounce_channel instances.

Test Plan (bench params: TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=5, N_BTN=2):
- Reset, then idle for 40 cycles -> sample_tick high on cycles 4, 8, 12, ... after reset release; all btn outputs stay 0.
- Hold btn_raw[0]=1 from cycle 0 -> btn_level[0] rises on the 3rd tick after the synchronised edge; btn_press[0] high for exactly 1 cycle that edge; btn_hold[0] asserts 5 ticks later.
- Pulse btn_raw[1] high for 6 cycles (under 3 ticks) three times, separated by 2 low cycles -> btn_level[1] never changes; no pulses.
- Release channel 0 after hold -> btn_level[0] falls after 3 ticks; btn_release[0] pulses 1 cycle; btn_hold[0] clears the same cycle.
- Raise both raw inputs on the same cycle -> btn_press = 2'b11 in a single cycle.
- Assert reset for 1 cycle while channel 0 is debounced high and the raw input is still held -> outputs drop to 0 with no release pulse; btn_press[0] re-fires after 3 ticks.
